// File: rtl/data_ram_ctrl_pkg.sv
// data_ram_ctrl_pkg: shared widths, FSM states and the range helper for the data RAM controller
package data_ram_ctrl_pkg;
  localparam int REG_BUS = 32;
  localparam int DATA_RAM_LAT_DEFAULT = 2;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} st_e;
  function automatic logic out_of_range(input logic [31:0] a, input int aw);
    return (a >> (aw + 2)) != '0;
  endfunction
endpackage

// File: rtl/data_ram_ctrl_if.sv
// data_ram_ctrl_if: core data-memory port bundle between the CPU core and the data RAM
interface data_ram_ctrl_if;
  import data_ram_ctrl_pkg::*;
  logic ce_i;
  logic we_i;
  logic [31:0] addr_i;
  logic [3:0] sel_i;
  logic [REG_BUS-1:0] data_i;
  logic [REG_BUS-1:0] data_o;
  logic stallreq_o;
  logic err_o;
  modport master(output ce_i, we_i, addr_i, sel_i, data_i, input data_o, stallreq_o, err_o);
  modport slave(input ce_i, we_i, addr_i, sel_i, data_i, output data_o, stallreq_o, err_o);
endinterface

// File: rtl/data_ram_array.sv
// data_ram_array: word-addressed SRAM with byte-lane writes and an enabled, clearable registered read port
module data_ram_array
  import data_ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [3:0]         sel,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [REG_BUS-1:0] wdata,
  input  logic               re,
  input  logic               rclr,
  output logic [REG_BUS-1:0] rdata
);
  logic [REG_BUS-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we)
      for (int k = 0; k < 4; k++)
        if (sel[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
  // the read register doubles as the held data_o, so it only moves on the edge into DONE
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata <= '0;
    else if (re) rdata <= rclr ? '0 : mem[addr];
endmodule

// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: data-memory responder, posted byte-lane writes, READ_LAT-cycle stalled reads
// Optional range checking with err_o when DATA_RAM_RANGE_CHECK_EN is defined.
module data_ram_ctrl
  import data_ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int READ_LAT = DATA_RAM_LAT_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  data_ram_ctrl_if.slave bus
);
  localparam int CW = $clog2(READ_LAT + 1);
  st_e state;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] idx_q, idx;
  logic oor, oor_q, req_rd, req_wr, last, rclr, err_q;
  logic [REG_BUS-1:0] rdata;
  logic unused_addr;
  assign unused_addr = ^{bus.addr_i[31:ADDR_W+2], bus.addr_i[1:0]};
`ifdef DATA_RAM_RANGE_CHECK_EN
  assign oor = out_of_range(bus.addr_i, ADDR_W);
`else
  assign oor = 1'b0;
`endif
  assign idx = state == ST_IDLE ? bus.addr_i[ADDR_W+1:2] : idx_q;
  assign req_rd = state == ST_IDLE && bus.ce_i && !bus.we_i;
  assign req_wr = state == ST_IDLE && bus.ce_i && bus.we_i;
  // last: this cycle's edge moves the read into DONE, so the array must fetch now
  assign last = req_rd ? READ_LAT == 1 : state == ST_BUSY && bus.ce_i && cnt == CW'(1);
  assign rclr = state == ST_IDLE ? oor : oor_q;
  assign bus.stallreq_o = rst && (req_rd || state == ST_BUSY);
  assign bus.data_o = rdata;
  assign bus.err_o = err_q;
  data_ram_array #(.ADDR_W(ADDR_W)) u_array (
    .clk(clk), .rst(rst), .we(req_wr && !oor), .sel(bus.sel_i), .addr(idx),
    .wdata(bus.data_i), .re(last), .rclr(rclr), .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      idx_q <= '0;
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= (req_wr && oor) || (last && rclr);
      case (state)
        ST_IDLE: if (req_rd) begin
          idx_q <= idx;
          oor_q <= oor;
          cnt <= CW'(READ_LAT - 1);
          state <= last ? ST_DONE : ST_BUSY;
        end
        ST_BUSY: begin
          cnt <= cnt - CW'(1);
          state <= !bus.ce_i ? ST_IDLE : last ? ST_DONE : ST_BUSY;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule
